// File: rtl/fb_read_arbiter_pkg.sv
// Shared frame-buffer geometry and debug-reader FSM state encoding
// for the port-B read arbiter.
package fb_read_arbiter_pkg;

  localparam int FB_DEPTH_WORDS = 76800;
  localparam int FB_BYTES       = 4 * FB_DEPTH_WORDS;
  localparam int FB_ADDR_W      = 19;
  localparam int FB_WADDR_W     = FB_ADDR_W - 2;

  typedef enum logic [1:0] {
    DBG_IDLE,
    DBG_ISSUE,
    DBG_WAIT,
    DBG_ACK
  } dbg_state_e;

endpackage

// File: rtl/fb_read_arbiter_byte_sel.sv
// Picks one greyscale byte out of a packed 4-pixel RAM word.
// Lane n is bits [8n+7:8n].
module fb_byte_sel (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = word_i[7:0];
    case (lane_i)
      2'd1:    byte_o = word_i[15:8];
      2'd2:    byte_o = word_i[23:16];
      2'd3:    byte_o = word_i[31:24];
      default: byte_o = word_i[7:0];
    endcase
  end

endmodule

// File: rtl/fb_read_arbiter.sv
// Shares frame-buffer port B between the HDMI scan-out (fixed slots) and a
// req/ack debug reader. reset_i is asynchronous and active-low.
module fb_read_arbiter
  import fb_read_arbiter_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int WADDR_W     = FB_WADDR_W,
  parameter int DEPTH_WORDS = FB_DEPTH_WORDS
) (
  input  logic               pixclk_i,
  input  logic               reset_i,
  input  logic               hdmi_active_i,
  input  logic [ADDR_W-1:0]  hdmi_addr_i,
  output logic [7:0]         pix_out_o,
  output logic [WADDR_W-1:0] ram_addr_o,
  output logic               ram_rd_o,
  input  logic [31:0]        ram_rdata_i,
  input  logic               dbg_req_i,
  input  logic [ADDR_W-1:0]  dbg_addr_i,
  output logic               dbg_ack_o,
  output logic [7:0]         dbg_data_o,
  output logic               dbg_oor_o
);

  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  logic hdmi_slot;
  logic hdmi_in_range;
  logic dbg_in_range;

  assign hdmi_slot     = hdmi_active_i && (hdmi_addr_i[1:0] == 2'b00);
  assign hdmi_in_range = 32'(hdmi_addr_i) < BYTE_LIMIT;
  assign dbg_in_range  = 32'(dbg_addr_i) < BYTE_LIMIT;

  // HDMI side: lane/valid delayed two cycles to line up with the RAM word.
  logic        hv1_q, hv2_q;
  logic [1:0]  hlane1_q, hlane2_q;
  logic [31:0] hword_q;
  logic        hword_vld_q;
  logic [31:0] hdmi_word;
  logic [7:0]  hdmi_byte;

  always_ff @(posedge pixclk_i or negedge reset_i) begin
    if (!reset_i) begin
      hv1_q       <= 1'b0;
      hv2_q       <= 1'b0;
      hlane1_q    <= 2'd0;
      hlane2_q    <= 2'd0;
      hword_q     <= 32'd0;
      hword_vld_q <= 1'b0;
    end else begin
      hv1_q    <= hdmi_active_i && hdmi_in_range;
      hlane1_q <= hdmi_addr_i[1:0];
      hv2_q    <= hv1_q;
      hlane2_q <= hlane1_q;
      if (hv2_q && (hlane2_q == 2'd0)) begin
        hword_q     <= ram_rdata_i;
        hword_vld_q <= 1'b1;
      end else if (!hv2_q) begin
        hword_vld_q <= 1'b0;
      end
    end
  end

  // Lane 0 is served straight from the RAM output; lanes 1..3 from the held word.
  assign hdmi_word = (hlane2_q == 2'd0) ? ram_rdata_i : hword_q;

  fb_byte_sel u_hdmi_sel (
    .word_i (hdmi_word),
    .lane_i (hlane2_q),
    .byte_o (hdmi_byte)
  );

  assign pix_out_o = (hv2_q && ((hlane2_q == 2'd0) || hword_vld_q)) ? hdmi_byte : 8'd0;

  // Debug FSM and the shared RAM address register.
  dbg_state_e         state_q, state_d;
  logic [WADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic               ram_rd_q, ram_rd_d;
  logic [1:0]         dbg_lane_q, dbg_lane_d;
  logic [7:0]         dbg_data_q, dbg_data_d;
  logic               dbg_oor_q, dbg_oor_d;
  logic [7:0]         dbg_byte;

  fb_byte_sel u_dbg_sel (
    .word_i (ram_rdata_i),
    .lane_i (dbg_lane_q),
    .byte_o (dbg_byte)
  );

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = 1'b0;
    dbg_lane_d = dbg_lane_q;
    dbg_data_d = dbg_data_q;
    dbg_oor_d  = dbg_oor_q;

    if (hdmi_slot) begin
      ram_addr_d = hdmi_addr_i[ADDR_W-1:2];
      ram_rd_d   = 1'b1;
    end

    case (state_q)
      DBG_IDLE: begin
        // Slots are never adjacent, so a blocked request waits one cycle at most.
        if (dbg_req_i && !hdmi_slot) begin
          if (dbg_in_range) begin
            ram_addr_d = dbg_addr_i[ADDR_W-1:2];
            ram_rd_d   = 1'b1;
            dbg_lane_d = dbg_addr_i[1:0];
            dbg_oor_d  = 1'b0;
            state_d    = DBG_ISSUE;
          end else begin
            dbg_oor_d  = 1'b1;
            dbg_data_d = 8'd0;
            state_d    = DBG_ACK;
          end
        end
      end
      DBG_ISSUE: state_d = DBG_WAIT;
      DBG_WAIT: begin
        dbg_data_d = dbg_byte;
        state_d    = DBG_ACK;
      end
      DBG_ACK:   state_d = DBG_IDLE;
      default:   state_d = DBG_IDLE;
    endcase
  end

  always_ff @(posedge pixclk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= DBG_IDLE;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      dbg_lane_q <= 2'd0;
      dbg_data_q <= 8'd0;
      dbg_oor_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      dbg_lane_q <= dbg_lane_d;
      dbg_data_q <= dbg_data_d;
      dbg_oor_q  <= dbg_oor_d;
    end
  end

  assign ram_addr_o = ram_addr_q;
  assign ram_rd_o   = ram_rd_q;
  assign dbg_ack_o  = (state_q == DBG_ACK);
  assign dbg_data_o = dbg_data_q;
  assign dbg_oor_o  = dbg_oor_q;

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Bench for fb_read_arbiter: vector table for the directed scenarios, a
// reset-during-read sequence, and random debug reads against a RAM model.
`timescale 1ns/1ps
module tb_fb_read_arbiter;

  localparam int WORDS = 76800;
  localparam int BYTES = 4 * WORDS;
  localparam int HIST  = 4096;

  logic        pixclk = 1'b0;
  logic        reset;
  logic        hdmi_active;
  logic [18:0] hdmi_addr;
  logic [7:0]  pix_out;
  logic [16:0] ram_addr;
  logic        ram_rd;
  logic [31:0] ram_rdata;
  logic        dbg_req;
  logic [18:0] dbg_addr;
  logic        dbg_ack;
  logic [7:0]  dbg_data;
  logic        dbg_oor;

  fb_read_arbiter dut (
    .pixclk_i      (pixclk),
    .reset_i       (reset),
    .hdmi_active_i (hdmi_active),
    .hdmi_addr_i   (hdmi_addr),
    .pix_out_o     (pix_out),
    .ram_addr_o    (ram_addr),
    .ram_rd_o      (ram_rd),
    .ram_rdata_i   (ram_rdata),
    .dbg_req_i     (dbg_req),
    .dbg_addr_i    (dbg_addr),
    .dbg_ack_o     (dbg_ack),
    .dbg_data_o    (dbg_data),
    .dbg_oor_o     (dbg_oor)
  );

  always #5 pixclk = ~pixclk;

  // Frame buffer: registered read, data one cycle after the address.
  logic [31:0] mem [0:WORDS-1];
  always @(posedge pixclk)
    ram_rdata <= (int'(ram_addr) < WORDS) ? mem[ram_addr] : 32'hDEAD_BEEF;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic        h_act  [0:HIST-1];
  logic [18:0] h_addr [0:HIST-1];

  typedef struct {
    logic act; logic [18:0] ha; logic req; logic [18:0] da;
    logic [7:0] pix; logic [16:0] ra; logic rd; logic ack; logic [7:0] dd; logic oor;
  } vec_t;
  vec_t tbl [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic act, input logic [18:0] ha, input logic req, input logic [18:0] da);
    hdmi_active = act;
    hdmi_addr   = ha;
    dbg_req     = req;
    dbg_addr    = da;
    h_act[cyc]  = act;
    h_addr[cyc] = ha;
  endtask

  task automatic tick();
    @(posedge pixclk);
    #1;
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix"}, 32'(pix_out), 0);
    chk({tag, "_raddr"}, 32'(ram_addr), 0);
    chk({tag, "_rd"}, 32'(ram_rd), 0);
    chk({tag, "_ack"}, 32'(dbg_ack), 0);
    chk({tag, "_data"}, 32'(dbg_data), 0);
    chk({tag, "_oor"}, 32'(dbg_oor), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 19'd0, 1'b0, 19'd0);
    repeat (2) @(posedge pixclk);
    @(negedge pixclk);
    check_zero("reset");
    reset = 1'b1;
    @(posedge pixclk);
    #1;
    cyc = 0;
    for (int i = 0; i < HIST; i++) begin
      h_act[i]  = 1'b0;
      h_addr[i] = 19'd0;
    end
  endtask

  // Pixel expected on the output in cycle c: the byte addressed two cycles
  // earlier, provided its whole word has been streamed in order since lane 0.
  function automatic logic [7:0] exp_pix(input int c);
    int s, a, ln;
    logic [31:0] w;
    s = c - 2;
    if (s < 0) return 8'h00;
    if (!h_act[s] || int'(h_addr[s]) >= BYTES) return 8'h00;
    a  = int'(h_addr[s]);
    ln = a % 4;
    for (int j = 1; j <= ln; j++)
      if (s - j < 0 || !h_act[s-j] || int'(h_addr[s-j]) != a - j) return 8'h00;
    w = mem[a / 4];
    return 8'((w >> (8 * ln)) & 32'hFF);
  endfunction

  task automatic set_row(input int i, input logic act, input int ha, input logic req, input int da,
                         input logic [7:0] pix, input int ra, input logic rd, input logic ack,
                         input logic [7:0] dd, input logic oor);
    tbl[i] = '{act, 19'(ha), req, 19'(da), pix, 17'(ra), rd, ack, dd, oor};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, lat, nreads, gap, grant_c, ack_c, base;
    logic req_on, a;
    logic [18:0] ha, da;
    logic [7:0] dd, exp_dd;
    logic [31:0] w;

    for (int i = 0; i < WORDS; i++) mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    mem[0] = 32'h4433_2211;
    mem[1] = 32'hDDCC_BBAA;
    mem[2] = 32'h7856_3412;
    mem[3] = 32'h8765_4321;

    //          c  act ha      req da      pix    ram_addr rd ack dd     oor
    set_row( 0, 1,  0,      0, 0,      8'h00, 0,     0, 0, 8'h00, 0);
    set_row( 1, 1,  1,      1, 6,      8'h00, 0,     1, 0, 8'h00, 0);
    set_row( 2, 1,  2,      1, 6,      8'h11, 1,     1, 0, 8'h00, 0);
    set_row( 3, 1,  3,      1, 6,      8'h22, 1,     0, 0, 8'h00, 0);
    set_row( 4, 1,  4,      1, 6,      8'h33, 1,     0, 1, 8'hCC, 0);
    set_row( 5, 1,  5,      0, 0,      8'h44, 1,     1, 0, 8'hCC, 0);
    set_row( 6, 1,  6,      0, 0,      8'hAA, 1,     0, 0, 8'hCC, 0);
    set_row( 7, 1,  7,      0, 0,      8'hBB, 1,     0, 0, 8'hCC, 0);
    set_row( 8, 1,  8,      1, 9,      8'hCC, 1,     0, 0, 8'hCC, 0);
    set_row( 9, 1,  9,      1, 9,      8'hDD, 2,     1, 0, 8'hCC, 0);
    set_row(10, 1, 10,      1, 9,      8'h12, 2,     1, 0, 8'hCC, 0);
    set_row(11, 1, 11,      1, 9,      8'h34, 2,     0, 0, 8'hCC, 0);
    set_row(12, 1, 12,      1, 9,      8'h56, 2,     0, 1, 8'h34, 0);
    set_row(13, 1, 13,      0, 0,      8'h78, 3,     1, 0, 8'h34, 0);
    set_row(14, 1, 14,      1, BYTES,  8'h21, 3,     0, 0, 8'h34, 0);
    set_row(15, 1, 15,      1, BYTES,  8'h43, 3,     0, 1, 8'h00, 1);
    set_row(16, 1, BYTES,   0, 0,      8'h65, 3,     0, 0, 8'h00, 1);
    set_row(17, 1, BYTES+1, 0, 0,      8'h87, WORDS, 1, 0, 8'h00, 1);
    set_row(18, 1, BYTES+2, 0, 0,      8'h00, WORDS, 0, 0, 8'h00, 1);
    set_row(19, 1, BYTES+3, 0, 0,      8'h00, WORDS, 0, 0, 8'h00, 1);
    for (int i = 20; i < 26; i++)
      set_row(i, 0, i,      0, 0,      8'h00, WORDS, 0, 0, 8'h00, 1);

    // Directed scenarios: in-order scan, debug grant, slot collision, out of range.
    do_reset();
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].act, tbl[i].ha, tbl[i].req, tbl[i].da);
      @(negedge pixclk);
      chk("tbl_pix", 32'(pix_out), 32'(tbl[i].pix));
      chk("tbl_raddr", 32'(ram_addr), 32'(tbl[i].ra));
      chk("tbl_rd", 32'(ram_rd), 32'(tbl[i].rd));
      chk("tbl_ack", 32'(dbg_ack), 32'(tbl[i].ack));
      chk("tbl_data", 32'(dbg_data), 32'(tbl[i].dd));
      chk("tbl_oor", 32'(dbg_oor), 32'(tbl[i].oor));
      if (tbl[i].ack) $display("table row %0d: dbg ack data=0x%02h oor=%0d", i, dbg_data, dbg_oor);
      tick();
    end

    // Reset lands while the debug read is in ISSUE: no ack may follow.
    do_reset();
    drive(1'b1, 19'd0, 1'b0, 19'd0);
    @(negedge pixclk);
    tick();
    drive(1'b1, 19'd1, 1'b1, 19'd6);
    @(negedge pixclk);
    tick();
    drive(1'b1, 19'd2, 1'b1, 19'd6);
    #1;
    chk("pre_reset_pix", 32'(pix_out), 32'h11);
    reset = 1'b0;
    drive(1'b0, 19'd0, 1'b0, 19'd0);
    #1;
    check_zero("midreset");
    repeat (2) @(posedge pixclk);
    @(negedge pixclk);
    reset = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      @(negedge pixclk);
      chk("no_stale_ack", 32'(dbg_ack), 0);
      tick();
    end
    drive(1'b0, 19'd0, 1'b1, 19'd9);
    got = 0;
    lat = 0;
    dd  = 8'd0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(negedge pixclk);
      if (dbg_ack) begin
        got = 1;
        lat = k;
        dd  = dbg_data;
      end
      tick();
    end
    drive(1'b0, 19'd0, 1'b0, 19'd0);
    chk("post_reset_ack_seen", 32'(got), 1);
    chk("post_reset_latency", 32'(lat), 3);
    chk("post_reset_data", 32'(dd), 32'h34);
    $display("post-reset read: addr=9 ack_after=%0d data=0x%02h", lat, dd);

    // Random debug reads during a full-rate scan that wraps past the last byte.
    do_reset();
    base    = BYTES - 256 + int'($urandom_range(0, 3));
    nreads  = 0;
    gap     = 0;
    req_on  = 1'b0;
    da      = 19'd0;
    grant_c = -10;
    ack_c   = -10;
    while (cyc < 4000 && nreads < 100) begin
      a  = (cyc % 80) < 64;
      ha = 19'((base + cyc) % BYTES);
      if (!req_on && gap == 0) begin
        req_on = 1'b1;
        if ($urandom_range(0, 7) == 0) da = 19'(BYTES + int'($urandom_range(0, 4095)));
        else da = 19'($urandom_range(0, BYTES - 1));
        grant_c = (a && ha[1:0] == 2'b00) ? cyc + 1 : cyc;
        ack_c   = grant_c + ((int'(da) < BYTES) ? 3 : 1);
      end else if (!req_on) begin
        gap--;
      end
      drive(a, ha, req_on, req_on ? da : 19'd0);
      @(negedge pixclk);
      chk("rand_pix", 32'(pix_out), 32'(exp_pix(cyc)));
      if (req_on && cyc == grant_c + 1 && int'(da) < BYTES) begin
        chk("rand_grant_rd", 32'(ram_rd), 1);
        chk("rand_grant_addr", 32'(ram_addr), 32'(da) >> 2);
      end
      chk("rand_ack", 32'(dbg_ack), 32'(req_on && cyc == ack_c));
      if (req_on && cyc == ack_c) begin
        if (int'(da) < BYTES) begin
          w      = mem[int'(da) / 4];
          exp_dd = 8'((w >> (8 * (int'(da) % 4))) & 32'hFF);
        end else begin
          exp_dd = 8'h00;
        end
        chk("rand_data", 32'(dbg_data), 32'(exp_dd));
        chk("rand_oor", 32'(dbg_oor), 32'(int'(da) >= BYTES));
        $display("debug read %0d: addr=%0d data=0x%02h oor=%0d", nreads, da, dbg_data, dbg_oor);
        req_on = 1'b0;
        gap    = int'($urandom_range(0, 3));
        nreads++;
      end
      tick();
    end
    chk("rand_reads_done", 32'(nreads), 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
